// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg
//   Shared types and constants for the instruction fetch slice.
//   - RESET_PC_DEFAULT : default first fetch address after reset
//   - INST_WIDTH       : instruction word width
//   - NOP_INST         : canonical no-op (addi x0,x0,0), used as idle filler
//   - fetch_state_e    : fetch FSM states (HALT only reachable when
//                        IFETCH_MISALIGN_CHECK_EN is defined)
//   - fetch_entry_t    : buffered {address, instruction word} pair
package instruction_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INST_WIDTH       = 32;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]           addr;
        logic [INST_WIDTH-1:0] word;
    } fetch_entry_t;

    // Sequential fetch advance; wraps naturally at 32 bits.
    function automatic logic [31:0] pc_incr(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// fetch_fifo
//   Synchronous FIFO holding fetched {addr, word} entries.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     flush       : drop all entries (wins over push/pop in the same cycle)
//     push        : write push_data at the tail (caller guarantees not full)
//     push_data   : entry to write
//     pop         : remove head entry (ignored when empty)
//     head        : head entry, all-zero while empty
//     count       : number of entries held
//   DEPTH must be a power of two so the pointers wrap by overflow.
module fetch_fifo
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_pop;

    assign do_pop = pop && (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: head is masked to zero whenever count is 0.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetch unit: issues word reads to a synchronous instruction memory with
//   a fixed 1-cycle latency, buffers returned words in fetch_fifo and hands
//   them to the decoder. Taken branches/jumps redirect the fetch PC and
//   discard everything fetched on the old path.
//   Optional feature macro: IFETCH_MISALIGN_CHECK_EN
//     defined   : a redirect target with addr[1:0] != 0 parks the unit in
//                 HALT (fetch_fault=1, no requests) until an aligned redirect.
//     undefined : target low bits are forced to 0, fetch_fault is tied 0.
//   Ports:
//     clk, rst_n              : clock, asynchronous active-low reset
//     imem_req/imem_addr      : memory read request and word address
//     imem_rdata/imem_rvalid  : read data, one cycle after imem_req
//     instruction/inst_addr   : head instruction and its address
//     inst_valid/inst_ready   : downstream handshake
//     redirect_valid/_addr    : one-cycle redirect pulse and new target
//     fetch_fault             : misaligned redirect target seen (macro only)
//     dbg_state               : current FSM state, for observation
//
//   Handshake: inst_valid/inst_ready follow strict valid/ready rules. A
//   transfer happens on a rising edge where both are high. Once inst_valid
//   rises, instruction/inst_addr hold and inst_valid stays high until that
//   transfer; the only exception is a redirect, which flushes the buffer.
//   inst_valid never depends on inst_ready.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [31:0]           imem_addr,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    input  logic                  imem_rvalid,
    output logic [INST_WIDTH-1:0] instruction,
    output logic [31:0]           inst_addr,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_addr,
    output logic                  fetch_fault,
    output fetch_state_e          dbg_state
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = CW + 1;

    fetch_state_e  state;
    fetch_state_e  state_nxt;
    logic [31:0]   pc;
    logic [31:0]   issued_addr;
    logic          outstanding;
    logic          kill;

    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_data;
    logic          push;
    logic          pop;
    logic          issue;
    logic [OW-1:0] occupancy;
    logic [31:0]   target;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, issue decision, redirect target
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
`ifdef IFETCH_MISALIGN_CHECK_EN
        target = redirect_addr;
        if (redirect_valid) begin
            state_nxt = (redirect_addr[1:0] != 2'b00) ? ST_HALT : ST_RUN;
        end
`else
        target = redirect_addr & 32'hFFFF_FFFC;
`endif
        // Slots already promised: buffered entries plus the response in
        // flight, less the entry leaving this cycle. Counting the pop lets a
        // 2-deep buffer sustain one instruction per cycle.
        occupancy = OW'(count) + OW'(outstanding) - OW'(pop);
        issue     = rst_n && !redirect_valid && (state == ST_RUN) &&
                    (occupancy < OW'(FIFO_DEPTH));
    end

    assign imem_req  = issue;
    assign imem_addr = pc;

    // ------------------------------------------------------------------
    // PC, in-flight tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            issued_addr <= '0;
            outstanding <= 1'b0;
            kill        <= 1'b0;
        end else begin
            outstanding <= issue;
            if (issue) begin
                issued_addr <= pc;
            end
            if (redirect_valid) begin
                pc <= target;
            end else if (issue) begin
                pc <= pc_incr(pc);
            end
            // With a fixed 1-cycle latency the stale response lands in the
            // redirect cycle itself and is dropped there; kill only covers a
            // request that is still pending after the redirect.
            if (redirect_valid) begin
                kill <= outstanding && !imem_rvalid;
            end else if (imem_rvalid) begin
                kill <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response buffering and downstream handshake
    // ------------------------------------------------------------------
    assign pop            = inst_valid && inst_ready;
    assign push           = imem_rvalid && !kill && !redirect_valid && (state == ST_RUN);
    assign push_data.addr = issued_addr;
    assign push_data.word = imem_rdata;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign inst_valid  = (count != '0);
    assign instruction = head.word;
    assign inst_addr   = head.addr;
    assign dbg_state   = state;

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign fetch_fault = (state == ST_HALT);
`else
    assign fetch_fault = 1'b0;
`endif

endmodule
